hpu_lmrw_lsu_req: RTL
=====================

# hpu_lmrw_lsu_req

LSU-side initiator for the local-memory read/write port. It accepts one scalar load or store at a time from the LSU pipeline and issues it to the local-memory responder on the `lsu_lmrw__*` port. If the responder reports a bank conflict, the block retries until the access succeeds, then returns a single response to the LSU. It sits between the LSU pipeline and the local-memory banks and is the only driver of the LSU read/write port.

## Interface
- `ADDR_WTH`, 32, byte address width (`pc_t`).
- `DATA_WTH`, 32, scalar data width (`data_t`).
- `RETRY_LIMIT`, 4, consecutive failures of one request before `starve_o` asserts; range 1..255.
- Clock/reset: one clock; reset is asynchronous and active-high.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_vld_i`  in  1  LSU request valid.
- `req_rdy_o`  out  1  request accepted when high together with `req_vld_i`.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  ADDR_WTH  byte address.
- `req_wdata_i`  in  DATA_WTH  store data.
- `req_wstrb_i`  in  4  store byte strobe.
- `rsp_vld_o`  out  1  one-cycle response pulse; the consumer cannot backpressure it.
- `rsp_err_o`  out  1  address outside local memory (`addr[18]=1`).
- `rsp_rdata_o`  out  DATA_WTH  load data; 0 for stores and errors.
- `lsu_lmrw__wr_en_o`, `lsu_lmrw__waddr_o` (ADDR_WTH), `lsu_lmrw__wdata_o` (DATA_WTH), `lsu_lmrw__wstrb_o` (4)  out  write port.
- `lsu_lmrw__rd_en_o`, `lsu_lmrw__raddr_o` (ADDR_WTH)  out  read port.
- `lmrw_lsu__wr_suc_i`  in  1  write success; valid 1 cycle after `wr_en`.
- `lmrw_lsu__rd_suc_i`  in  1  read success; valid 1 cycle after `rd_en`.
- `lmrw_lsu__rdata_i`  in  DATA_WTH  read word; valid 2 cycles after `rd_en`.
- `starve_o`  out  1  the current request has failed at least `RETRY_LIMIT` consecutive times.
- `fail_cnt_o`  out  8  consecutive failure count for the current request; saturates at 255.

## Operation
- FSM states: IDLE, ISSUE, CHECK, RDATA.
- `req_rdy_o` = (state == IDLE). Only one request is outstanding at a time.
- On accept, the block latches we, addr, wdata and wstrb into registers and clears `fail_cnt`.
  - If `addr[18]=1`: no memory access. Next state is IDLE, with `rsp_vld_o=1`, `rsp_err_o=1` and `rsp_rdata_o=0` in the following cycle.
  - Otherwise the next state is ISSUE.
- ISSUE:
  - Drive `wr_en` (store) or `rd_en` (load) high for exactly one cycle.
  - Both the waddr and raddr outputs carry the latched address. wdata and wstrb carry the latched values.
  - Next state is CHECK.
- CHECK: both enables are low. Sample `wr_suc_i` for a store or `rd_suc_i` for a load.
  - Store success: go to IDLE with `rsp_vld_o=1` next cycle.
  - Load success: go to RDATA.
  - Failure: increment `fail_cnt` (saturating) and go back to ISSUE.
- RDATA: capture `lmrw_lsu__rdata_i` into `rsp_rdata_o`, then go to IDLE with `rsp_vld_o=1` next cycle.
- `starve_o` is registered and equals `fail_cnt >= RETRY_LIMIT`. It clears on the next accept.
- The `*_suc_i` inputs are ignored in every state other than CHECK. The responder updates them every cycle, so they carry no meaning elsewhere.
- Response registers (`rsp_vld_o`, `rsp_err_o`, `rsp_rdata_o`) are rewritten only when a response is produced. `rsp_vld_o` is cleared in every other cycle.

## Timing
- Reset values: state IDLE; `req_rdy_o=1` (combinational from IDLE); all other outputs, enables, addresses, data and counters 0.
- Reset asserted mid-request drops the request: no enable and no response afterwards.
- Let accept be cycle A:
  - Error response: `rsp_vld_o` at A+1.
  - Store: enable at A+1, suc sampled at A+2, `rsp_vld_o` at A+3.
  - Load: enable at A+1, suc sampled at A+2, data captured at A+3, `rsp_vld_o` at A+4.
- Each failure adds 2 cycles: the re-issue happens 2 cycles after the previous enable.
- Back-to-back requests: the cycle carrying `rsp_vld_o` is an IDLE cycle, so a new request can be accepted in that same cycle. Response and accept may coincide.
- At most one of `wr_en`/`rd_en` is high in any cycle. Neither is high in two consecutive cycles.

## Test plan
- Store, no conflict: addr `0x0000_8004`, wdata `0xDEADBEEF`, wstrb `0xF`; `wr_suc=1` at A+2 -> exactly one `wr_en` at A+1 with those values; `rsp_vld=1`, `err=0` at A+3; `fail_cnt=0`.
- Load, no conflict: addr `0x0000_0010`; `rd_suc=1` at A+2, rdata `0x12345678` at A+3 -> `rsp_rdata=0x12345678` with `rsp_vld` at A+4.
- Conflicts: a load whose `rd_suc=0` on its first 5 checks, then 1 -> 6 `rd_en` pulses at A+1, +3, +5, +7, +9, +11; `fail_cnt_o` reaches 5; `starve_o=1` from the 4th failure on; response at A+14; next accept clears both.
- Out-of-range: store to `0x0004_0000` -> no `wr_en`; `rsp_vld=1`, `err=1`, `rdata=0` at A+1.
- Back-to-back: a store followed by a load with `req_vld` held -> the second accept lands in the cycle of the first response; response ordering is preserved.
- Reset mid-request: `rst_i` asserted during CHECK with `rd_suc=0` -> all outputs 0 immediately; no further enables or responses.

Source files
------------

// File: rtl/hpu_lmrw_lsu_req.sv
// rtl/hpu_lmrw_lsu_req.sv - LSU initiator for the local-memory read/write port
// One scalar load/store at a time; re-issues on bank conflict until it succeeds.
module hpu_lmrw_lsu_req #(
  parameter int ADDR_WTH    = 32,
  parameter int DATA_WTH    = 32,
  parameter int RETRY_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_vld_i,
  output logic                req_rdy_o,
  input  logic                req_we_i,
  input  logic [ADDR_WTH-1:0] req_addr_i,
  input  logic [DATA_WTH-1:0] req_wdata_i,
  input  logic [3:0]          req_wstrb_i,
  output logic                rsp_vld_o,
  output logic                rsp_err_o,
  output logic [DATA_WTH-1:0] rsp_rdata_o,
  output logic                lsu_lmrw__wr_en_o,
  output logic [ADDR_WTH-1:0] lsu_lmrw__waddr_o,
  output logic [DATA_WTH-1:0] lsu_lmrw__wdata_o,
  output logic [3:0]          lsu_lmrw__wstrb_o,
  output logic                lsu_lmrw__rd_en_o,
  output logic [ADDR_WTH-1:0] lsu_lmrw__raddr_o,
  input  logic                lmrw_lsu__wr_suc_i,
  input  logic                lmrw_lsu__rd_suc_i,
  input  logic [DATA_WTH-1:0] lmrw_lsu__rdata_i,
  output logic                starve_o,
  output logic [7:0]          fail_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RDATA} state_t;

  state_t              state;
  logic                we_q;
  logic [ADDR_WTH-1:0] addr_q;
  logic [DATA_WTH-1:0] wdata_q;
  logic [3:0]          wstrb_q;
  logic [7:0]          fail_cnt_q;
  logic [7:0]          fail_nxt;
  logic                suc;

  assign req_rdy_o         = (state == IDLE);
  assign lsu_lmrw__waddr_o = addr_q;
  assign lsu_lmrw__raddr_o = addr_q;
  assign lsu_lmrw__wdata_o = wdata_q;
  assign lsu_lmrw__wstrb_o = wstrb_q;
  assign fail_cnt_o        = fail_cnt_q;
  assign fail_nxt          = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
  assign suc               = we_q ? lmrw_lsu__wr_suc_i : lmrw_lsu__rd_suc_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      we_q              <= 1'b0;
      addr_q            <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      fail_cnt_q        <= '0;
      starve_o          <= 1'b0;
      rsp_vld_o         <= 1'b0;
      rsp_err_o         <= 1'b0;
      rsp_rdata_o       <= '0;
      lsu_lmrw__wr_en_o <= 1'b0;
      lsu_lmrw__rd_en_o <= 1'b0;
    end else begin
      // Enables and the response strobe are single-cycle pulses by default.
      rsp_vld_o         <= 1'b0;
      lsu_lmrw__wr_en_o <= 1'b0;
      lsu_lmrw__rd_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld_i) begin
            we_q       <= req_we_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            wstrb_q    <= req_wstrb_i;
            fail_cnt_q <= '0;
            starve_o   <= 1'b0;
            if (req_addr_i[18]) begin
              rsp_vld_o   <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              state             <= ISSUE;
              lsu_lmrw__wr_en_o <= req_we_i;
              lsu_lmrw__rd_en_o <= ~req_we_i;
            end
          end
        end
        ISSUE: state <= CHECK;
        CHECK: begin
          if (suc) begin
            if (we_q) begin
              rsp_vld_o   <= 1'b1;
              rsp_err_o   <= 1'b0;
              rsp_rdata_o <= '0;
              state       <= IDLE;
            end else begin
              state <= RDATA;
            end
          end else begin
            // Conflict: re-arm the same enable so the retry lands in ISSUE.
            fail_cnt_q        <= fail_nxt;
            starve_o          <= (fail_nxt >= 8'(RETRY_LIMIT));
            lsu_lmrw__wr_en_o <= we_q;
            lsu_lmrw__rd_en_o <= ~we_q;
            state             <= ISSUE;
          end
        end
        RDATA: begin
          rsp_vld_o   <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= lmrw_lsu__rdata_i;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
